// File: rtl/axi_ro_mem_responder.sv
// Read-only AXI burst responder over a byte-writable fill memory.
// One burst outstanding at a time; synchronous one-cycle read feeds the R channel register.
module axi_ro_mem_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ID_W-1:0]          s_axi_arid,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_W-1:0]          s_axi_rid,
  output logic [DATA_W-1:0]        s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [DATA_W/8-1:0]      wr_strb_i,
  output logic                     busy_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic                arready_q;
  logic                rvalid_q, rlast_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ID_W-1:0]     rid_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q;
  logic [1:0]          burst_q;
  logic                werr_q;
  logic [8:0]          cnt_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ar_hs, r_hs, last_hs, issue, oor, wrap_bad;
  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   incr_addr, wrap_mask;
  logic                unused_araddr;

  assign unused_araddr = ^s_axi_araddr[1:0];

  assign ar_hs   = arready_q & s_axi_arvalid;
  assign r_hs    = rvalid_q & s_axi_rready;
  assign last_hs = r_hs & rlast_q;
  assign issue   = (state_q == BURST) && (cnt_q != ({1'b0, len_q} + 9'd1))
                   && (!rvalid_q || s_axi_rready);

  assign wrap_bad = (s_axi_arburst == 2'b10) &&
                    (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) || (s_axi_arsize != 3'b010));

  // Any address bit above the word index means the beat falls outside the memory.
  assign oor = (addr_q >> (IDX_W + 2)) != '0;
  assign idx = addr_q[IDX_W+1:2];

  assign incr_addr = addr_q + ADDR_W'(4);
  assign wrap_mask = ADDR_W'({len_q, 2'b11});

  always_comb begin
    addr_d = incr_addr;
    case (burst_q)
      2'b00:   addr_d = addr_q;
      2'b10:   addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: addr_d = incr_addr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs)   state_d = BURST;
      BURST:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // arready is registered so it stays low throughout reset and rises on the first edge after.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rid_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      werr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      arready_q <= (state_d == IDLE);
      if (ar_hs) begin
        rid_q   <= s_axi_arid;
        addr_q  <= {s_axi_araddr[ADDR_W-1:2], 2'b00};
        len_q   <= s_axi_arlen;
        burst_q <= s_axi_arburst;
        werr_q  <= wrap_bad;
        cnt_q   <= '0;
      end
      if (issue) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (cnt_q == {1'b0, len_q});
        if (werr_q || oor) begin
          rresp_q <= 2'b10;
          rdata_q <= '0;
        end else begin
          rresp_q <= 2'b00;
          rdata_q <= mem[idx];
        end
        addr_q <= addr_d;
        cnt_q  <= cnt_q + 9'd1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb_i[b]) mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign busy_o        = (state_q == BURST);

endmodule

// File: tb/tb_axi_ro_mem_responder.sv
// Bench for axi_ro_mem_responder: directed and randomized bursts checked against a word-array model.
module tb_axi_ro_mem_responder;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DEPTH  = 1024;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic              wr_en_i;
  logic [9:0]        wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic [3:0]        wr_strb_i;
  logic              busy_o;

  axi_ro_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)
  ) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] mdl [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [7:0] len,
                                            input logic [1:0] burst, input int unsigned k);
    int unsigned sz, lower;
    case (burst)
      2'b00: return base;
      2'b10: begin
        sz    = (int'(len) + 1) * 4;
        lower = (base / sz) * sz;
        return lower + ((base - lower + 4 * k) % sz);
      end
      default: return base + 4 * k;
    endcase
  endfunction

  task automatic fill(input int unsigned a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_addr_i = a[9:0]; wr_data_i = d; wr_strb_i = s;
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
    mdl[a] = merge(mdl[a], d, s);
  endtask

  task automatic chk_reset_outs();
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rid", s_axi_rid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  // mode: 0 rready always high, 1 pattern 1,0,0,1, 2 random.
  // side_wr writes the first burst word in the cycle beat 0 is read.
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          input int abort_beat, input bit side_wr,
                          input logic [31:0] sw_data, input logic [3:0] sw_strb);
    logic [31:0] e_data [256];
    logic [1:0]  e_resp [256];
    logic [31:0] base, a, h_data;
    logic [1:0]  h_resp;
    logic        h_last, h_id_unused, werr, rr, held;
    logic [3:0]  h_id;
    int          beat, cyc;
    base = addr & ~32'h3;
    werr = (burst == 2'b10) && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || size != 3'b010);
    for (int k = 0; k <= int'(len); k++) begin
      if (k == 1 && side_wr) mdl[base >> 2] = merge(mdl[base >> 2], sw_data, sw_strb);
      a = beat_addr(base, len, burst, k);
      if (werr || a >= DEPTH * 4) begin
        e_data[k] = '0; e_resp[k] = 2'b10;
      end else begin
        e_data[k] = mdl[a >> 2]; e_resp[k] = 2'b00;
      end
    end
    if (side_wr && len == 0) mdl[base >> 2] = merge(mdl[base >> 2], sw_data, sw_strb);

    @(negedge clk_i);
    s_axi_arvalid = 1'b1; s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_rready = 1'b0;
    chk("arready_idle", s_axi_arready, 1);
    chk("busy_idle", busy_o, 0);
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    chk("busy_t1", busy_o, 1);
    chk("arready_t1", s_axi_arready, 0);
    @(negedge clk_i);
    chk("rvalid_t1", s_axi_rvalid, 0);
    if (side_wr) begin
      wr_en_i = 1'b1; wr_addr_i = base[11:2]; wr_data_i = sw_data; wr_strb_i = sw_strb;
    end

    beat = 0; cyc = 0; held = 1'b0;
    h_data = '0; h_resp = '0; h_last = 1'b0; h_id = '0; h_id_unused = 1'b0;
    while (beat <= int'(len) && cyc < 1000) begin
      @(negedge clk_i);
      wr_en_i = 1'b0;
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rr;
      if (cyc == 0) chk("rvalid_t2", s_axi_rvalid, 1);
      else if (mode == 0) chk("rvalid_cont", s_axi_rvalid, 1);
      if (abort_beat == beat && s_axi_rvalid) begin
        rst_n_i = 1'b0;
        #1;
        chk_reset_outs();
        s_axi_rready = 1'b0;
        return;
      end
      if (held) begin
        chk("hold_rvalid", s_axi_rvalid, 1);
        chk("hold_rdata", s_axi_rdata, h_data);
        chk("hold_rresp", s_axi_rresp, h_resp);
        chk("hold_rlast", s_axi_rlast, h_last);
        chk("hold_rid", s_axi_rid, h_id);
      end
      if (s_axi_rvalid) begin
        if (rr) begin
          chk("rdata", s_axi_rdata, e_data[beat]);
          chk("rresp", s_axi_rresp, e_resp[beat]);
          chk("rlast", s_axi_rlast, (beat == int'(len)));
          chk("rid", s_axi_rid, id);
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          h_data = s_axi_rdata; h_resp = s_axi_rresp; h_last = s_axi_rlast; h_id = s_axi_rid;
        end
      end
      cyc++;
    end
    if (beat <= int'(len)) chk("beat_timeout", beat, int'(len) + 1);
    @(negedge clk_i);
    s_axi_rready = 1'b0;
    chk("done_rvalid", s_axi_rvalid, 0);
    chk("done_arready", s_axi_arready, 1);
    chk("done_busy", busy_o, 0);
  endtask

  initial begin
    logic [1:0]  bt;
    logic [7:0]  ln;
    logic [2:0]  sz;
    logic [31:0] ad;
    rst_n_i = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_strb_i = '0;

    #12;
    chk_reset_outs();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1 chk("arready_prerise", s_axi_arready, 0);
    @(negedge clk_i);
    chk("arready_rise", s_axi_arready, 1);

    for (int unsigned i = 0; i < DEPTH; i++) fill(i, $urandom, 4'hF);
    for (int unsigned i = 0; i < 8; i++) fill(i, 32'hA0 + i, 4'hF);

    do_burst(4'd3, 32'h0, 8'd7, 3'b010, 2'b01, 0, -1, 1'b0, '0, '0);
    do_burst(4'd3, 32'h0, 8'd7, 3'b010, 2'b01, 1, -1, 1'b0, '0, '0);
    do_burst(4'd1, 32'h18, 8'd3, 3'b010, 2'b10, 0, -1, 1'b0, '0, '0);
    do_burst(4'd2, 32'h18, 8'd2, 3'b010, 2'b10, 1, -1, 1'b0, '0, '0);
    do_burst(4'd2, 32'h18, 8'd3, 3'b001, 2'b10, 0, -1, 1'b0, '0, '0);
    do_burst(4'd5, 32'hFF8, 8'd3, 3'b010, 2'b01, 0, -1, 1'b0, '0, '0);
    do_burst(4'd6, 32'hFFB, 8'd3, 3'b010, 2'b01, 2, -1, 1'b0, '0, '0);
    do_burst(4'd7, 32'h21, 8'd0, 3'b010, 2'b01, 0, -1, 1'b0, '0, '0);

    fill(5, 32'h11223344, 4'hF);
    fill(5, 32'hFFFFFFFF, 4'b0010);
    chk("strb_model", mdl[5], 32'h1122FF44);
    do_burst(4'd4, 32'h14, 8'd1, 3'b010, 2'b00, 0, -1, 1'b0, '0, '0);

    do_burst(4'd8, 32'h40, 8'd2, 3'b010, 2'b00, 0, -1, 1'b1, 32'hDEADBEEF, 4'hF);
    do_burst(4'd9, 32'h80, 8'd3, 3'b010, 2'b01, 2, -1, 1'b1, 32'h5A5A5A5A, 4'b0101);

    for (int n = 0; n < 24; n++) begin
      bt = 2'($urandom_range(0, 2));
      ln = ($urandom_range(0, 3) != 0 && bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1)
                                                      : 8'($urandom_range(0, 15));
      sz = ($urandom_range(0, 5) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
      ad = $urandom_range(0, 32'h10FF);
      fill($urandom_range(0, DEPTH - 1), $urandom, 4'($urandom_range(0, 15)));
      do_burst(4'($urandom), ad, ln, sz, bt, $urandom_range(0, 2), -1, 1'b0, '0, '0);
    end

    do_burst(4'd10, 32'hE00, 8'd255, 3'b010, 2'b01, 2, -1, 1'b0, '0, '0);

    do_burst(4'd11, 32'h100, 8'd15, 3'b010, 2'b01, 0, 3, 1'b0, '0, '0);
    repeat (2) @(negedge clk_i);
    chk("abort_rvalid_held", s_axi_rvalid, 0);
    rst_n_i = 1'b1;
    #1 chk("abort_arready_pre", s_axi_arready, 0);
    @(negedge clk_i);
    chk("abort_arready_rise", s_axi_arready, 1);
    do_burst(4'd12, 32'h100, 8'd15, 3'b010, 2'b01, 0, -1, 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
